// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared rv32i types: ID/EX bundle, ALU ops, skid-register states
package rv32i_pkg;

    localparam int DPW = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef struct packed {
        logic [1:0]     resultsrc;
        logic           memwrite;
        logic           alusrc;
        logic           regwrite;
        alu_op_t        alu_ctrl;
        logic [DPW-1:0] src_a;
        logic [DPW-1:0] rd2;
        logic [4:0]     rd;
        logic [DPW-1:0] immext;
        logic [DPW-1:0] pc;
    } id_ex_t;

    // Encodings double as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/id_ex_skid_reg_sat_counter.sv
// rtl/id_ex_skid_reg_sat_counter.sv - saturating up-counter, cleared only by reset
module sat_counter #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    output logic [CNTW-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {CNTW{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_skid_reg.sv
// rtl/id_ex_skid_reg.sv - ID/EX pipeline register with valid/ready, optional skid entry, flush, stall count
module id_ex_skid_reg
    import rv32i_pkg::*;
#(
    parameter int PW   = $bits(id_ex_t),
    parameter int SKID = 1,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            valid_d_i,
    output logic            ready_d_o,
    input  logic [PW-1:0]   payload_d_i,
    output logic            valid_e_o,
    input  logic            ready_e_i,
    output logic [PW-1:0]   payload_e_o,
    output logic [1:0]      occ_o,
    output logic [CNTW-1:0] stall_cnt_o
);

    skid_state_t   state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          ready_q;
    logic          in_fire, out_fire;

    assign valid_e_o   = (state_q != EMPTY);
    assign payload_e_o = main_q;
    assign occ_o       = state_q;

    // Skid mode breaks the ready_e_i -> ready_d_o path with a register.
    assign ready_d_o = (SKID != 0) ? ready_q : (!valid_e_o || ready_e_i);

    assign in_fire  = valid_d_i && ready_d_o;
    assign out_fire = valid_e_o && ready_e_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = payload_d_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = payload_d_i;
                    end else if (in_fire && (SKID != 0)) begin
                        skid_d  = payload_d_i;
                        state_d = TWO;
                    end else if (out_fire) begin
                        // Bubble: execute sees regwrite/memwrite low.
                        main_d  = '0;
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != TWO);
        end
    end

    sat_counter #(
        .CNTW (CNTW)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (valid_e_o && !ready_e_i),
        .count (stall_cnt_o)
    );

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// tb/tb_id_ex_skid_reg.sv - directed bench for id_ex_skid_reg in skid, single-register and narrow-counter builds
module tb_id_ex_skid_reg;
    import rv32i_pkg::*;

    localparam int PW = $bits(id_ex_t);

    logic   clk;
    logic   rst_n;
    logic   flush;
    logic   valid_d;
    logic   ready_e;
    id_ex_t payload_d;

    logic        r1_ready, r1_valid;
    id_ex_t      r1_payload;
    logic [1:0]  r1_occ;
    logic [15:0] r1_cnt;

    logic        r0_ready, r0_valid;
    id_ex_t      r0_payload;
    logic [1:0]  r0_occ;
    logic [15:0] r0_cnt;

    logic        rs_ready, rs_valid;
    id_ex_t      rs_payload;
    logic [1:0]  rs_occ;
    logic [3:0]  rs_cnt;

    int n_checks;
    int n_fail;

    id_ex_skid_reg #(.PW(PW), .SKID(1), .CNTW(16)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .valid_d_i(valid_d), .ready_d_o(r1_ready), .payload_d_i(payload_d),
        .valid_e_o(r1_valid), .ready_e_i(ready_e), .payload_e_o(r1_payload),
        .occ_o(r1_occ), .stall_cnt_o(r1_cnt)
    );

    id_ex_skid_reg #(.PW(PW), .SKID(0), .CNTW(16)) u_noskid (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .valid_d_i(valid_d), .ready_d_o(r0_ready), .payload_d_i(payload_d),
        .valid_e_o(r0_valid), .ready_e_i(ready_e), .payload_e_o(r0_payload),
        .occ_o(r0_occ), .stall_cnt_o(r0_cnt)
    );

    id_ex_skid_reg #(.PW(PW), .SKID(1), .CNTW(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .valid_d_i(valid_d), .ready_d_o(rs_ready), .payload_d_i(payload_d),
        .valid_e_o(rs_valid), .ready_e_i(ready_e), .payload_e_o(rs_payload),
        .occ_o(rs_occ), .stall_cnt_o(rs_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic id_ex_t mk(input logic [31:0] pc);
        id_ex_t p;
        p          = '0;
        p.pc       = pc;
        p.immext   = pc + 32'd1;
        p.rd       = pc[6:2];
        p.regwrite = 1'b1;
        p.memwrite = pc[2];
        p.alu_ctrl = ALU_ADD;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        valid_d   = 1'b0;
        ready_e   = 1'b0;
        payload_d = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (r1_occ !== 2'd0) begin $display("FAIL reset_occ actual=%0d required=0", r1_occ); n_fail++; end
        n_checks++; if (r1_valid !== 1'b0) begin $display("FAIL reset_valid actual=%b required=0", r1_valid); n_fail++; end
        n_checks++; if (r1_ready !== 1'b1) begin $display("FAIL reset_ready_skid actual=%b required=1", r1_ready); n_fail++; end
        n_checks++; if (r0_ready !== 1'b1) begin $display("FAIL reset_ready_noskid actual=%b required=1", r0_ready); n_fail++; end
        n_checks++; if (r1_payload !== id_ex_t'('0)) begin $display("FAIL reset_payload actual=%h required=0", r1_payload); n_fail++; end
        n_checks++; if (r1_cnt !== 16'd0) begin $display("FAIL reset_cnt actual=%0d required=0", r1_cnt); n_fail++; end
    endtask

    task automatic test_streaming();
        id_ex_t exp;
        do_reset();
        ready_e   = 1'b1;
        valid_d   = 1'b1;
        payload_d = mk(32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = mk(32'(4 * i));
            n_checks++; if (r1_payload !== exp) begin $display("FAIL stream_payload%0d actual=%h required=%h", i, r1_payload.pc, exp.pc); n_fail++; end
            n_checks++; if (r1_occ !== 2'd1 || r1_valid !== 1'b1) begin $display("FAIL stream_occ%0d actual=%0d/%b required=1/1", i, r1_occ, r1_valid); n_fail++; end
            n_checks++; if (r1_ready !== 1'b1) begin $display("FAIL stream_ready%0d actual=%b required=1", i, r1_ready); n_fail++; end
            payload_d = mk(32'(4 * (i + 1)));
        end
        valid_d = 1'b0;
        tick();
        n_checks++; if (r1_occ !== 2'd0 || r1_payload !== id_ex_t'('0)) begin $display("FAIL stream_drain actual=%0d/%h required=0/0", r1_occ, r1_payload); n_fail++; end
        n_checks++; if (r1_cnt !== 16'd0) begin $display("FAIL stream_cnt actual=%0d required=0", r1_cnt); n_fail++; end
    endtask

    task automatic test_back_pressure();
        id_ex_t exp;
        do_reset();
        ready_e   = 1'b0;
        valid_d   = 1'b1;
        payload_d = mk(32'h10);
        tick();
        n_checks++; if (r1_occ !== 2'd1 || r1_ready !== 1'b1) begin $display("FAIL bp_first actual=%0d/%b required=1/1", r1_occ, r1_ready); n_fail++; end
        payload_d = mk(32'h14);
        tick();
        exp = mk(32'h10);
        n_checks++; if (r1_occ !== 2'd2 || r1_ready !== 1'b0) begin $display("FAIL bp_full actual=%0d/%b required=2/0", r1_occ, r1_ready); n_fail++; end
        n_checks++; if (r1_payload !== exp) begin $display("FAIL bp_head actual=%h required=%h", r1_payload.pc, exp.pc); n_fail++; end
        payload_d = mk(32'h18);
        tick();
        n_checks++; if (r1_occ !== 2'd2 || r1_payload !== exp) begin $display("FAIL bp_hold actual=%0d/%h required=2/%h", r1_occ, r1_payload.pc, exp.pc); n_fail++; end
        n_checks++; if (r1_cnt !== 16'd2) begin $display("FAIL bp_cnt_stall actual=%0d required=2", r1_cnt); n_fail++; end
        ready_e = 1'b1;
        tick();
        exp = mk(32'h14);
        n_checks++; if (r1_payload !== exp || r1_occ !== 2'd1 || r1_ready !== 1'b1) begin $display("FAIL bp_second actual=%h/%0d/%b required=%h/1/1", r1_payload.pc, r1_occ, r1_ready, exp.pc); n_fail++; end
        tick();
        exp = mk(32'h18);
        n_checks++; if (r1_payload !== exp || r1_occ !== 2'd1) begin $display("FAIL bp_third actual=%h/%0d required=%h/1", r1_payload.pc, r1_occ, exp.pc); n_fail++; end
        valid_d = 1'b0;
        tick();
        n_checks++; if (r1_occ !== 2'd0) begin $display("FAIL bp_drain actual=%0d required=0", r1_occ); n_fail++; end
        n_checks++; if (r1_cnt !== 16'd2) begin $display("FAIL bp_cnt_final actual=%0d required=2", r1_cnt); n_fail++; end
    endtask

    task automatic test_flush();
        do_reset();
        ready_e   = 1'b0;
        valid_d   = 1'b1;
        payload_d = mk(32'h20);
        tick();
        payload_d = mk(32'h24);
        tick();
        n_checks++; if (r1_occ !== 2'd2) begin $display("FAIL flush_fill actual=%0d required=2", r1_occ); n_fail++; end
        flush     = 1'b1;
        payload_d = mk(32'h28);
        tick();
        n_checks++; if (r1_occ !== 2'd0 || r1_valid !== 1'b0) begin $display("FAIL flush_state actual=%0d/%b required=0/0", r1_occ, r1_valid); n_fail++; end
        n_checks++; if (r1_payload !== id_ex_t'('0) || r1_payload.regwrite !== 1'b0 || r1_payload.memwrite !== 1'b0) begin $display("FAIL flush_payload actual=%h required=0", r1_payload); n_fail++; end
        n_checks++; if (r1_ready !== 1'b1) begin $display("FAIL flush_ready actual=%b required=1", r1_ready); n_fail++; end
        n_checks++; if (r1_cnt !== 16'd2) begin $display("FAIL flush_cnt_kept actual=%0d required=2", r1_cnt); n_fail++; end
        flush   = 1'b0;
        valid_d = 1'b0;
        tick();
        n_checks++; if (r1_occ !== 2'd0) begin $display("FAIL flush_discard actual=%0d required=0", r1_occ); n_fail++; end
    endtask

    task automatic test_noskid();
        id_ex_t exp;
        do_reset();
        ready_e   = 1'b1;
        valid_d   = 1'b1;
        payload_d = mk(32'h40);
        tick();
        exp = mk(32'h40);
        n_checks++; if (r0_payload !== exp || r0_occ !== 2'd1 || r0_ready !== 1'b1) begin $display("FAIL ns_first actual=%h/%0d/%b required=%h/1/1", r0_payload.pc, r0_occ, r0_ready, exp.pc); n_fail++; end
        payload_d = mk(32'h44);
        ready_e   = 1'b0;
        #1;
        n_checks++; if (r0_ready !== 1'b0) begin $display("FAIL ns_ready_comb_low actual=%b required=0", r0_ready); n_fail++; end
        tick();
        n_checks++; if (r0_payload !== exp || r0_occ !== 2'd1) begin $display("FAIL ns_hold actual=%h/%0d required=%h/1", r0_payload.pc, r0_occ, exp.pc); n_fail++; end
        ready_e = 1'b1;
        #1;
        n_checks++; if (r0_ready !== 1'b1) begin $display("FAIL ns_ready_comb_high actual=%b required=1", r0_ready); n_fail++; end
        tick();
        exp = mk(32'h44);
        n_checks++; if (r0_payload !== exp || r0_occ !== 2'd1) begin $display("FAIL ns_second actual=%h/%0d required=%h/1", r0_payload.pc, r0_occ, exp.pc); n_fail++; end
        valid_d = 1'b0;
        tick();
        n_checks++; if (r0_occ !== 2'd0 || r0_valid !== 1'b0) begin $display("FAIL ns_drain actual=%0d/%b required=0/0", r0_occ, r0_valid); n_fail++; end
        n_checks++; if (r0_cnt !== 16'd1) begin $display("FAIL ns_cnt actual=%0d required=1", r0_cnt); n_fail++; end
    endtask

    task automatic test_async_reset();
        id_ex_t exp;
        do_reset();
        ready_e   = 1'b0;
        valid_d   = 1'b1;
        payload_d = mk(32'h30);
        tick();
        payload_d = mk(32'h34);
        tick();
        n_checks++; if (r1_occ !== 2'd2) begin $display("FAIL ar_fill actual=%0d required=2", r1_occ); n_fail++; end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (r1_occ !== 2'd0 || r1_valid !== 1'b0 || r1_ready !== 1'b1) begin $display("FAIL ar_immediate actual=%0d/%b/%b required=0/0/1", r1_occ, r1_valid, r1_ready); n_fail++; end
        n_checks++; if (r1_payload !== id_ex_t'('0) || r1_cnt !== 16'd0) begin $display("FAIL ar_clear actual=%h/%0d required=0/0", r1_payload, r1_cnt); n_fail++; end
        valid_d = 1'b0;
        ready_e = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++; if (r1_valid !== 1'b0) begin $display("FAIL ar_idle actual=%b required=0", r1_valid); n_fail++; end
        valid_d   = 1'b1;
        payload_d = mk(32'h50);
        tick();
        exp = mk(32'h50);
        n_checks++; if (r1_valid !== 1'b1 || r1_payload !== exp) begin $display("FAIL ar_first actual=%b/%h required=1/%h", r1_valid, r1_payload.pc, exp.pc); n_fail++; end
        valid_d = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        ready_e   = 1'b0;
        valid_d   = 1'b1;
        payload_d = mk(32'h60);
        tick();
        valid_d = 1'b0;
        repeat (14) tick();
        n_checks++; if (rs_cnt !== 4'd14) begin $display("FAIL sat_mid actual=%0d required=14", rs_cnt); n_fail++; end
        repeat (6) tick();
        n_checks++; if (rs_cnt !== 4'd15) begin $display("FAIL sat_hold actual=%0d required=15", rs_cnt); n_fail++; end
        n_checks++; if (r1_cnt !== 16'd20) begin $display("FAIL sat_wide actual=%0d required=20", r1_cnt); n_fail++; end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_noskid();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_skid_reg.md
# id_ex_skid_reg

Parametrised decode-to-execute pipeline register with a valid/ready handshake, an optional two-entry skid buffer, synchronous flush and a saturating stall counter. It sits between the decode logic (control unit, register file read, immediate extend) and the execute stage of the rv32i core. It replaces the fixed always-enabled ID/EX register so that execute back-pressure stalls decode without dropping or duplicating instructions.

## Interface
Parameters:
- PW, default $bits(id_ex_t): payload width in bits; the payload is the packed ID/EX bundle.
- SKID, default 1: 1 selects the two-entry skid buffer (registered ready_d_o); 0 selects a single register (combinational ready_d_o).
- CNTW, default 16: width of the stall counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous kill of all held entries (branch mispredict, trap).
- valid_d_i  in  1  decode presents a valid instruction.
- ready_d_o  out  1  register can accept from decode this cycle.
- payload_d_i  in  PW  ID/EX bundle from decode.
- valid_e_o  out  1  execute-side payload is valid.
- ready_e_i  in  1  execute consumes this cycle.
- payload_e_o  out  PW  ID/EX bundle to execute, always driven from the main register.
- occ_o  out  2  entries held: 0, 1 or 2.
- stall_cnt_o  out  CNTW  saturating count of cycles with valid_e_o=1 and ready_e_i=0.

## Operation
- Input fire: valid_d_i && ready_d_o. Output fire: valid_e_o && ready_e_i.
- SKID=1 states:
  - EMPTY, occ 0: on input fire, main ← payload_d_i and go to ONE.
  - ONE, occ 1:
    - input fire and output fire: main ← payload_d_i, stay in ONE.
    - input fire only: skid ← payload_d_i, go to TWO.
    - output fire only: go to EMPTY.
  - TWO, occ 2: on output fire, main ← skid and go to ONE. Input cannot fire in TWO.
- SKID=1 ready: ready_d_o = (state != TWO), taken from a register. There is no combinational path from ready_e_i.
- SKID=0: single main register only.
  - ready_d_o = !valid_e_o || ready_e_i.
  - occ_o is 0 or 1.
  - The TWO state does not exist.
- Flush:
  - flush_i=1 forces EMPTY at the next edge and zeroes main and skid.
  - An input fire in the same cycle is discarded.
  - Flush has priority over every other transition.
- Zeroing:
  - Whenever the state enters EMPTY, the main payload is cleared to all-zero, so regwrite and memwrite reach execute as 0 (bubble).
  - The skid payload is cleared whenever the state leaves TWO.
- Payload ordering: strictly FIFO. No instruction is ever lost or duplicated outside a flush.
- Stall counter:
  - Increments when valid_e_o && !ready_e_i.
  - Saturates at 2^CNTW−1.
  - Cleared only by reset; flush does not clear it.

## Timing
- Reset (rst_n=0, asynchronous): state EMPTY, main and skid all-zero, valid_e_o=0, occ_o=0, stall_cnt_o=0. ready_d_o=1 in both modes.
- Latency: one cycle from input fire to valid_e_o=1 with the payload when the register is empty.
- Throughput: one instruction per cycle while ready_e_i=1.
- Back-pressure, SKID=1: ready_d_o deasserts the cycle after the skid fills. It reasserts the cycle after the first output fire out of TWO.
- Simultaneous flush with output fire: the output fire counts as consumed, and the state is still EMPTY next cycle.
- Reset released mid-stream: no output until the first input fire after release.

## Structure
- rv32i_pkg holds:
  - id_ex_t, a packed struct: resultsrc, memwrite, alusrc, regwrite, alu_op_t alu_ctrl, srcA[DPW], rd2[DPW], rd[5], immext[DPW], pc[DPW].
  - The state enum skid_state_t {EMPTY, ONE, TWO}.
  - DPW.
- One sub-module, sat_counter #(CNTW), implements the stall counter. The state machine and payload registers stay in id_ex_skid_reg.

## Test plan
- Streaming: SKID=1, ready_e_i=1, valid_d_i=1 with payloads pc=0x0,0x4,0x8,0xC → the same sequence on payload_e_o one cycle later, occ_o=1 throughout, stall_cnt_o=0.
- Back-pressure: push pc=0x10,0x14,0x18 with ready_e_i=0 → occ_o goes 1 then 2, ready_d_o=0 after the second accept, 0x18 held on the input. Then raise ready_e_i → output 0x10,0x14,0x18 in order, stall_cnt_o equals the stalled cycles.
- Flush in TWO: fill both entries, assert flush_i with valid_d_i=1 → next cycle occ_o=0, valid_e_o=0, payload_e_o=0 (regwrite=0, memwrite=0), and the input is discarded.
- SKID=0 mode: ready_e_i toggling 1,0,1 with continuous input → ready_d_o follows !valid_e_o||ready_e_i combinationally, occ_o never exceeds 1, no loss.
- Async reset mid-operation: drop rst_n between edges while occ_o=2 → outputs are immediately at reset values. After release, the first input fire appears one cycle later.
- Counter saturation: CNTW=4, hold valid with ready_e_i=0 for 20 cycles → stall_cnt_o stops at 15.
